regfile_2r1w: RTL and testbench
===============================

# regfile_2r1w

Parametrised general-purpose register file for the datapath: one synchronous write port, two independent combinational read ports, and a per-register pending (scoreboard) bit that tracks outstanding writes. It replaces the fixed 8×16, single-read-port register file and feeds both ALU operand buses in the same cycle. The controller uses the scoreboard to stall operand reads until an earlier result has been written back.

## Interface
- DATA_W, 16, register width in bits
- DEPTH, 8, number of registers; 2..64, need not be a power of two
- IDX_W, $clog2(DEPTH), register index width (derived; not overridden)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- write  input  1  write enable
- writenum  input  IDX_W  write register index
- data_in  input  DATA_W  write data
- reserve  input  1  mark register reserve_num pending
- reserve_num  input  IDX_W  register to reserve
- readnum_a  input  IDX_W  read port A index
- readnum_b  input  IDX_W  read port B index
- data_out_a  output  DATA_W  read port A data
- data_out_b  output  DATA_W  read port B data
- busy_a  output  1  pending bit of readnum_a
- busy_b  output  1  pending bit of readnum_b
- pending  output  DEPTH  all pending bits, bit i = register i

## Operation
- Storage: DEPTH registers of DATA_W bits. Pending vector: DEPTH bits.
- Write: when write=1 and writenum<DEPTH, register[writenum] <= data_in at the clock edge, and pending[writenum] is cleared. A write to a non-pending register is legal.
- Reserve: when reserve=1 and reserve_num<DEPTH, pending[reserve_num] is set at the clock edge.
- Reserve and write in the same cycle to the same index: the data is written, and the pending bit ends up set. Reserve wins because the write retires an older producer.
- Reserve and write to different indices: both take effect.
- Reads: data_out_x = register[readnum_x] and busy_x = pending[readnum_x], combinational. Both ports may read the same index.
- Out-of-range index (index ≥ DEPTH): writes and reserves are ignored; reads return all-zero data and busy=0.
- No arithmetic. Indices are compared unsigned at full IDX_W width.

## Timing
- On rst_n low, asynchronously and immediately: all registers = 0, pending = 0. Therefore data_out_a/b = 0, busy_a/b = 0 and pending = 0 while reset is held.
- Reset deassertion is synchronised externally. The first write is accepted on the first rising edge with rst_n high.
- Reset asserted mid-operation: an in-flight write or reserve on that edge is lost, and all state is zero.
- Write latency: the new value is visible on a read port after 1 edge (the cycle after write=1), unless bypass is enabled.
- Pending latency: a reserve issued in cycle N gives busy=1 from cycle N+1. A write in cycle N gives busy=0 from cycle N+1, unless a same-index reserve occurs in cycle N.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - When write=1, writenum<DEPTH and readnum_x==writenum, data_out_x = data_in in the same cycle.
  - busy_x reads 0 in that cycle, unless reserve targets the same index in the same cycle.
- REGFILE_BYPASS_EN undefined: reads always return the stored value and stored pending bit. Same-cycle read-during-write returns old data and old busy.

## Structure
- Package regfile_pkg holds:
  - default DATA_W and DEPTH constants
  - a function returning the index width
  - typedef of the data word
- One sub-module, regfile_dec: a parametrised IDX_W-to-DEPTH one-hot decoder. Out-of-range input yields all-zero output. It is instantiated for the write index and the reserve index.
- Read muxing is inline in regfile_2r1w.

## Test plan
- Reset: hold rst_n=0 with random inputs toggling -> all outputs 0. Release, then read all indices -> data 0, busy 0.
- Write/read: write 16'hA5A5 to R3, then read A=3 and B=3 next cycle -> both 16'hA5A5. Write R7=16'h1234 while reading 7 in the same cycle -> old value without bypass, 16'h1234 with REGFILE_BYPASS_EN.
- Scoreboard: reserve R2 -> busy_b=1 next cycle with readnum_b=2, pending=8'b0000_0100. Write R2=16'h00FF -> busy_b=0 next cycle, data 16'h00FF.
- Collision: in one cycle, reserve R5 and write R5=16'hBEEF -> next cycle data 16'hBEEF with busy=1. Reserve R1 and write R6 together -> pending[1]=1, pending[6]=0.
- Non-power-of-two: DEPTH=6. Write index 7 with 16'hFFFF -> no register changes. Read index 6 -> data 0, busy 0.
- Async reset mid-stream: assert rst_n low between edges after R4 is written and reserved -> data and busy go to 0 immediately, before the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the 2-read/1-write register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;

  // Index width for a given register count. A depth of 1 still gets a
  // 1-bit index so that the port is never zero-width.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_dec.sv
// IDX_W-to-DEPTH one-hot decoder. An index at or above DEPTH decodes to all
// zeros, so out-of-range writes and reserves touch no register.
module regfile_dec
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [DEPTH-1:0] onehot
);

  // Full-width unsigned compare against every legal index.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < DEPTH; i++)
      onehot[i] = en && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: one synchronous write port, two combinational read ports and
// a per-register pending (scoreboard) bit.
// Optional feature macro: REGFILE_BYPASS_EN -- forwards same-cycle write data
// (and the resulting pending state) to a read port addressing the written
// register.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [IDX_W-1:0]  writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic              reserve,
  input  logic [IDX_W-1:0]  reserve_num,
  input  logic [IDX_W-1:0]  readnum_a,
  input  logic [IDX_W-1:0]  readnum_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [DEPTH-1:0]  pending
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             pend;
  logic [DEPTH-1:0]             wr_oh;
  logic [DEPTH-1:0]             rsv_oh;

  // Per-register view presented to the read muxes (stored or forwarded).
  logic [DEPTH-1:0][DATA_W-1:0] rd_word;
  logic [DEPTH-1:0]             rd_busy;

  regfile_dec #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_wr_dec (
    .en     (write),
    .idx    (writenum),
    .onehot (wr_oh)
  );

  regfile_dec #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_rsv_dec (
    .en     (reserve),
    .idx    (reserve_num),
    .onehot (rsv_oh)
  );

  // Storage and scoreboard update; a same-index reserve overrides the clear
  // from the write because the write retires an older producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_oh[i]) mem[i] <= data_in;
        pend[i] <= rsv_oh[i] | (pend[i] & ~wr_oh[i]);
      end
    end
  end

  // Per-register read value, optionally forwarding this cycle's write.
  always_comb begin
    rd_word = mem;
    rd_busy = pend;
`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < DEPTH; i++) begin
      // Gated by rst_n so that outputs stay zero while reset is held.
      if (wr_oh[i] && rst_n) begin
        rd_word[i] = data_in;
        rd_busy[i] = rsv_oh[i];
      end
    end
`endif
  end

  // Read muxes; an index with no matching register returns zero / not busy.
  always_comb begin
    data_out_a = '0;
    data_out_b = '0;
    busy_a     = 1'b0;
    busy_b     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (readnum_a == IDX_W'(i)) begin
        data_out_a = rd_word[i];
        busy_a     = rd_busy[i];
      end
      if (readnum_b == IDX_W'(i)) begin
        data_out_b = rd_word[i];
        busy_b     = rd_busy[i];
      end
    end
  end

  assign pending = pend;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a DEPTH=8 and a DEPTH=6 instance share one stimulus
// stream and are compared every cycle against an array-based reference model.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        reserve;
  logic [2:0]  reserve_num;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;

  logic [1:0][15:0] doa, dob;
  logic [1:0]       ba, bb;
  logic [7:0]       p8;
  logic [5:0]       p6;

  int nvec = 0;
  int nerr = 0;

  // Reference model: plain arrays, one slot per instance.
  logic [15:0] mmem  [2][8];
  bit          mpend [2][8];
  int          dep   [2] = '{8, 6};

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(16), .DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum),
    .data_in(data_in), .reserve(reserve), .reserve_num(reserve_num),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(doa[0]), .data_out_b(dob[0]),
    .busy_a(ba[0]), .busy_b(bb[0]), .pending(p8)
  );

  regfile_2r1w #(.DATA_W(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum),
    .data_in(data_in), .reserve(reserve), .reserve_num(reserve_num),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(doa[1]), .data_out_b(dob[1]),
    .busy_a(ba[1]), .busy_b(bb[1]), .pending(p6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_data(input int k, input logic [2:0] idx);
    if (!rst_n || int'(idx) >= dep[k]) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (write && writenum == idx) return data_in;
`endif
    return mmem[k][idx];
  endfunction

  function automatic logic exp_busy(input int k, input logic [2:0] idx);
    if (!rst_n || int'(idx) >= dep[k]) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (write && writenum == idx) return reserve && reserve_num == idx;
`endif
    return mpend[k][idx];
  endfunction

  function automatic logic [7:0] exp_pend(input int k);
    logic [7:0] v = '0;
    for (int i = 0; i < dep[k]; i++) v[i] = mpend[k][i];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        mmem[k][i]  = '0;
        mpend[k][i] = 1'b0;
      end
  endtask

  // Effect of one rising edge, using the inputs that were present at it.
  task automatic model_update();
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (write && int'(writenum) < dep[k]) begin
        mmem[k][writenum]  = data_in;
        mpend[k][writenum] = 1'b0;
      end
      if (reserve && int'(reserve_num) < dep[k])
        mpend[k][reserve_num] = 1'b1;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_data_a", dep[k]), 32'(doa[k]), 32'(exp_data(k, readnum_a)));
      chk($sformatf("d%0d_data_b", dep[k]), 32'(dob[k]), 32'(exp_data(k, readnum_b)));
      chk($sformatf("d%0d_busy_a", dep[k]), 32'(ba[k]),  32'(exp_busy(k, readnum_a)));
      chk($sformatf("d%0d_busy_b", dep[k]), 32'(bb[k]),  32'(exp_busy(k, readnum_b)));
    end
    chk("d8_pending", 32'(p8), 32'(exp_pend(0)));
    chk("d6_pending", 32'(p6), 32'(exp_pend(1)));
  endtask

  task automatic set_in(input logic w, input logic [2:0] wn, input logic [15:0] d,
                        input logic r, input logic [2:0] rn,
                        input logic [2:0] ra, input logic [2:0] rb);
    write = w; writenum = wn; data_in = d;
    reserve = r; reserve_num = rn; readnum_a = ra; readnum_b = rb;
  endtask

  task automatic set_rand();
    set_in($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  // Called at posedge+1 with inputs set: check mid-cycle, then clock.
  task automatic tick();
    #3 compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk); #1;

    // Reset held with inputs toggling: everything reads zero.
    for (int n = 0; n < 6; n++) begin
      set_rand();
      tick();
    end
    set_in(1, 3, 16'hFFFF, 1, 3, 3, 3);
    #2 chk("rst_data_a", 32'(doa[0]), 32'h0);
    chk("rst_busy_a", 32'(ba[0]), 32'h0);
    chk("rst_pending", 32'(p8), 32'h0);
    tick();

    // Release and sweep every index.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
      tick();
    end

    // Write R3, read it on both ports next cycle.
    set_in(1, 3, 16'hA5A5, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 3, 3);
    #2 chk("r3_a", 32'(doa[0]), 32'hA5A5);
    chk("r3_b", 32'(dob[0]), 32'hA5A5);
    tick();

    // Read-during-write on R7.
    set_in(1, 7, 16'h1234, 0, 0, 7, 7);
`ifdef REGFILE_BYPASS_EN
    #2 chk("r7_rdw", 32'(doa[0]), 32'h1234);
`else
    #2 chk("r7_rdw", 32'(doa[0]), 32'h0000);
`endif
    tick();
    set_in(0, 0, 0, 0, 0, 7, 7);
    #2 chk("r7_after", 32'(dob[0]), 32'h1234);
    tick();

    // Scoreboard: reserve R2, then retire it with a write.
    set_in(0, 0, 0, 1, 2, 0, 2); tick();
    set_in(0, 0, 0, 0, 0, 0, 2);
    #2 chk("r2_busy", 32'(bb[0]), 32'h1);
    chk("r2_pending", 32'(p8), 32'h04);
    tick();
    set_in(1, 2, 16'h00FF, 0, 0, 2, 2); tick();
    set_in(0, 0, 0, 0, 0, 0, 2);
    #2 chk("r2_clear", 32'(bb[0]), 32'h0);
    chk("r2_data", 32'(dob[0]), 32'h00FF);
    tick();

    // Same-index collision: reserve wins the pending bit, data still lands.
    set_in(1, 5, 16'hBEEF, 1, 5, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 5, 5);
    #2 chk("r5_data", 32'(doa[0]), 32'hBEEF);
    chk("r5_busy", 32'(ba[0]), 32'h1);
    tick();

    // Different indices in the same cycle.
    set_in(1, 6, 16'h5555, 1, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 1, 6);
    #2 chk("p1_set", 32'(p8[1]), 32'h1);
    chk("p6_clr", 32'(p8[6]), 32'h0);
    tick();

    // DEPTH=6 instance: out-of-range write/reserve ignored, reads zero.
    set_in(1, 7, 16'hFFFF, 1, 7, 6, 7); tick();
    set_in(0, 0, 0, 0, 0, 6, 7);
    #2 chk("d6_idx6_data", 32'(doa[1]), 32'h0);
    chk("d6_idx6_busy", 32'(ba[1]), 32'h0);
    chk("d6_idx7_data", 32'(dob[1]), 32'h0);
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      set_rand();
      tick();
    end

    // Asynchronous reset between edges after R4 is written and reserved.
    set_in(1, 4, 16'hC0DE, 0, 0, 4, 4); tick();
    set_in(0, 0, 0, 1, 4, 4, 4); tick();
    set_in(0, 0, 0, 0, 0, 4, 4);
    #2 chk("r4_pre_data", 32'(doa[0]), 32'hC0DE);
    chk("r4_pre_busy", 32'(ba[0]), 32'h1);
    #1 rst_n = 1'b0;
    model_clear();
    #1 chk("r4_rst_data", 32'(doa[0]), 32'h0);
    chk("r4_rst_busy", 32'(bb[0]), 32'h0);
    chk("r4_rst_pending", 32'(p8), 32'h0);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
    set_in(1, 4, 16'h7777, 1, 4, 4, 4);
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 4, 4);
    tick();
    for (int n = 0; n < 20; n++) begin
      set_rand();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
